mem_access_unit: RTL and testbench

//  Load/store sequencer between the EX stage and data_memory.
//  - Accepts one memory request per transaction over a valid/ready handshake.
//  - Drives address/writeData/MemR/MemW into data_memory and captures readData after a fixed latency.
//  - Returns load results to write-back over a valid/ready handshake; stalls the pipeline via req_ready/busy.

---
 rtl/mem_access_unit.sv | 173 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the EX stage and data_memory, one request in flight at a time.
// Define MAU_FORWARD_EN to add a one-entry last-store forwarding register for loads.
module mem_access_unit #(
    parameter int DATA_W         = 32,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int READ_LATENCY   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_isLoad,
    input  logic              req_isStore,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic [DATA_W-1:0] address,
    output logic [DATA_W-1:0] writeData,
    output logic              MemR,
    output logic              MemW,
    input  logic [DATA_W-1:0] readData,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              err_range,
    output logic              busy
);
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {S_IDLE, S_STORE, S_LOAD, S_RESP, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [4:0]        rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              req_ready_q, busy_q, mem_r_q, mem_w_q, wb_valid_q;
    logic              out_of_range, accept, fwd_hit;

`ifdef MAU_FORWARD_EN
    logic              fwd_valid_q, fwd_valid_d;
    logic [DATA_W-1:0] fwd_addr_q, fwd_addr_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    assign fwd_hit = fwd_valid_q && (fwd_addr_q == req_addr);
`else
    assign fwd_hit = 1'b0;
`endif

    assign out_of_range = |req_addr[DATA_W-1:MEM_DEPTH_LOG2];
    // req_ready_q is 0 on the first cycle after reset release, so gate accept with it
    assign accept       = req_valid && req_ready_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wb_data_d = wb_data_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`ifdef MAU_FORWARD_EN
        fwd_valid_d = fwd_valid_q;
        fwd_addr_d  = fwd_addr_q;
        fwd_data_d  = fwd_data_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    if (req_isLoad && req_isStore) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (!req_isLoad && !req_isStore) begin
                        state_d = S_DONE;
                    end else if (out_of_range) begin
                        err_d = 1'b1;
                        if (req_isLoad) begin
                            wb_data_d = '0;
                            state_d   = S_RESP;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else if (req_isStore) begin
                        state_d = S_STORE;
                    end else if (fwd_hit) begin
`ifdef MAU_FORWARD_EN
                        wb_data_d = fwd_data_q;
`endif
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CNT_W'(READ_LATENCY - 1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_STORE: begin
`ifdef MAU_FORWARD_EN
                fwd_valid_d = 1'b1;
                fwd_addr_d  = addr_q;
                fwd_data_d  = wdata_q;
`endif
                state_d = S_IDLE;
            end
            S_LOAD: begin
                if (cnt_q == '0) begin
                    wb_data_d = readData;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP:  if (wb_ready) state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wb_data_q   <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            mem_r_q     <= 1'b0;
            mem_w_q     <= 1'b0;
            wb_valid_q  <= 1'b0;
`ifdef MAU_FORWARD_EN
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wb_data_q   <= wb_data_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            req_ready_q <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            mem_r_q     <= (state_d == S_LOAD);
            mem_w_q     <= (state_d == S_STORE);
            wb_valid_q  <= (state_d == S_RESP);
`ifdef MAU_FORWARD_EN
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign address   = addr_q;
    assign writeData = wdata_q;
    assign MemR      = mem_r_q;
    assign MemW      = mem_w_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = rd_q;
    assign wb_data   = wb_data_q;
    assign err_range = err_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a behavioural data_memory model.
module tb_mem_access_unit;
`ifdef MAU_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_ready, req_isLoad, req_isStore;
    logic [31:0] req_addr, req_wdata, address, writeData, readData, wb_data;
    logic [4:0]  req_rd, wb_rd;
    logic        MemR, MemW, wb_valid, wb_ready, err_range, busy;

    int checks = 0, errors = 0;
    int mr_cnt = 0, mw_cnt = 0, both_cnt = 0, err_cnt = 0, wbv_cnt = 0;
    logic [31:0] mem [0:2047];

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_isLoad(req_isLoad), .req_isStore(req_isStore), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .address(address), .writeData(writeData),
        .MemR(MemR), .MemW(MemW), .readData(readData), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .err_range(err_range),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign readData = MemR ? mem[address[10:0]] : 32'h0;
    always @(posedge clk) if (MemW) mem[address[10:0]] <= writeData;

    always @(negedge clk) begin
        if (MemR) mr_cnt++;
        if (MemW) mw_cnt++;
        if (MemR && MemW) both_cnt++;
        if (err_range) err_cnt++;
        if (wb_valid) wbv_cnt++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic ld, input logic st, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd);
        int k = 0;
        while (req_ready !== 1'b1 && k < 20) begin step(); k++; end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL send_ready got %b want 1", req_ready); end
        req_valid = 1'b1; req_isLoad = ld; req_isStore = st; req_addr = a; req_wdata = d; req_rd = rd;
        step();
        req_valid = 1'b0; req_isLoad = 1'b0; req_isStore = 1'b0;
    endtask

    task automatic wait_wbv(output int k);
        k = 0;
        while (wb_valid !== 1'b1 && k < 20) begin step(); k++; end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL wb_valid_timeout got %b want 1", wb_valid); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_isLoad = 1'b0; req_isStore = 1'b0;
        req_addr = '0; req_wdata = '0; req_rd = '0; wb_ready = 1'b1;
        repeat (3) step();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
        checks++; if ({MemR, MemW, wb_valid, err_range, busy} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b want 00000", {MemR, MemW, wb_valid, err_range, busy}); end
        checks++; if ({address, writeData, wb_data} !== 96'h0) begin errors++; $display("FAIL rst_data got %h want 0", {address, writeData, wb_data}); end
        rst_n = 1'b1;
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", req_ready); end
    endtask

    task automatic test_store_load();
        int k, m0;
        send(1'b0, 1'b1, 32'd5, 32'h1234, 5'd0);
        checks++; if ({MemW, MemR} !== 2'b10) begin errors++; $display("FAIL store_strobes got %b want 10", {MemW, MemR}); end
        checks++; if (address !== 32'd5) begin errors++; $display("FAIL store_addr got %0d want 5", address); end
        checks++; if (writeData !== 32'h1234) begin errors++; $display("FAIL store_wdata got %h want 1234", writeData); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL store_wbv got %b want 0", wb_valid); end
        step();
        checks++; if ({MemW, req_ready} !== 2'b01) begin errors++; $display("FAIL store_done got %b want 01", {MemW, req_ready}); end
        m0 = mr_cnt;
        send(1'b1, 1'b0, 32'd5, 32'h0, 5'd7);
        checks++; if (MemR !== !FWD) begin errors++; $display("FAIL load_memr got %b want %b", MemR, !FWD); end
        wait_wbv(k);
        checks++; if (k !== (FWD ? 0 : 1)) begin errors++; $display("FAIL load_latency got %0d want %0d", k, FWD ? 0 : 1); end
        checks++; if (wb_rd !== 5'd7) begin errors++; $display("FAIL load_rd got %0d want 7", wb_rd); end
        checks++; if (wb_data !== 32'h1234) begin errors++; $display("FAIL load_data got %h want 1234", wb_data); end
        step();
        checks++; if ({wb_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL load_done got %b want 01", {wb_valid, req_ready}); end
        checks++; if (mr_cnt - m0 !== (FWD ? 0 : 1)) begin errors++; $display("FAIL load_memr_cycles got %0d want %0d", mr_cnt - m0, FWD ? 0 : 1); end
    endtask

    task automatic test_backpressure();
        int k;
        send(1'b0, 1'b1, 32'd20, 32'hCAFE0001, 5'd0);
        step();
        wb_ready = 1'b0;
        send(1'b1, 1'b0, 32'd20, 32'h0, 5'd3);
        wait_wbv(k);
        for (int i = 0; i < 4; i++) begin
            checks++; if ({wb_valid, req_ready, busy} !== 3'b101) begin errors++; $display("FAIL hold_flags[%0d] got %b want 101", i, {wb_valid, req_ready, busy}); end
            checks++; if ({wb_rd, wb_data} !== {5'd3, 32'hCAFE0001}) begin errors++; $display("FAIL hold_data[%0d] got %0d/%h want 3/cafe0001", i, wb_rd, wb_data); end
            step();
        end
        wb_ready = 1'b1;
        step();
        checks++; if ({wb_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL hold_release got %b want 01", {wb_valid, req_ready}); end
    endtask

    task automatic test_range();
        int k, e0, m0, w0;
        e0 = err_cnt; m0 = mr_cnt; w0 = mw_cnt;
        wb_ready = 1'b0;
        send(1'b1, 1'b0, 32'd1024, 32'h0, 5'd4);
        checks++; if ({err_range, MemR} !== 2'b10) begin errors++; $display("FAIL oor_load_err got %b want 10", {err_range, MemR}); end
        wait_wbv(k);
        checks++; if ({wb_rd, wb_data} !== {5'd4, 32'h0}) begin errors++; $display("FAIL oor_load_data got %0d/%h want 4/0", wb_rd, wb_data); end
        wb_ready = 1'b1;
        step();
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL oor_load_pulse got %0d want 1", err_cnt - e0); end
        checks++; if (mr_cnt - m0 !== 0) begin errors++; $display("FAIL oor_load_memr got %0d want 0", mr_cnt - m0); end
        send(1'b0, 1'b1, 32'd1024, 32'h77, 5'd0);
        checks++; if ({err_range, MemW} !== 2'b10) begin errors++; $display("FAIL oor_store_err got %b want 10", {err_range, MemW}); end
        step();
        checks++; if ({err_range, req_ready} !== 2'b01) begin errors++; $display("FAIL oor_store_done got %b want 01", {err_range, req_ready}); end
        checks++; if (mw_cnt - w0 !== 0) begin errors++; $display("FAIL oor_store_memw got %0d want 0", mw_cnt - w0); end
        e0 = err_cnt;
        send(1'b0, 1'b1, 32'd1023, 32'hAA55, 5'd0);
        checks++; if ({MemW, err_range} !== 2'b10) begin errors++; $display("FAIL edge_store got %b want 10", {MemW, err_range}); end
        step();
        m0 = mr_cnt;
        wb_ready = 1'b0;
        send(1'b1, 1'b0, 32'd1023, 32'h0, 5'd8);
        wait_wbv(k);
        checks++; if (wb_data !== 32'hAA55) begin errors++; $display("FAIL edge_load_data got %h want aa55", wb_data); end
        checks++; if (mr_cnt - m0 !== (FWD ? 0 : 1)) begin errors++; $display("FAIL edge_load_memr got %0d want %0d", mr_cnt - m0, FWD ? 0 : 1); end
        wb_ready = 1'b1;
        step();
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL edge_err got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_special();
        int e0, m0, w0, v0;
        e0 = err_cnt; m0 = mr_cnt; w0 = mw_cnt; v0 = wbv_cnt;
        send(1'b1, 1'b1, 32'd5, 32'h99, 5'd1);
        checks++; if ({err_range, MemR, MemW} !== 3'b100) begin errors++; $display("FAIL illegal_n1 got %b want 100", {err_range, MemR, MemW}); end
        step(); step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL illegal_idle got %b want 1", req_ready); end
        checks++; if ({mr_cnt - m0, mw_cnt - w0, wbv_cnt - v0, err_cnt - e0} !== {32'd0, 32'd0, 32'd0, 32'd1}) begin errors++; $display("FAIL illegal_counts got %0d/%0d/%0d/%0d want 0/0/0/1", mr_cnt - m0, mw_cnt - w0, wbv_cnt - v0, err_cnt - e0); end
        e0 = err_cnt; m0 = mr_cnt; w0 = mw_cnt; v0 = wbv_cnt;
        send(1'b0, 1'b0, 32'd5, 32'h99, 5'd1);
        checks++; if ({req_ready, err_range} !== 2'b00) begin errors++; $display("FAIL noop_n1 got %b want 00", {req_ready, err_range}); end
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL noop_n2_ready got %b want 1", req_ready); end
        checks++; if ({mr_cnt - m0, mw_cnt - w0, wbv_cnt - v0, err_cnt - e0} !== 128'h0) begin errors++; $display("FAIL noop_counts got %0d/%0d/%0d/%0d want 0/0/0/0", mr_cnt - m0, mw_cnt - w0, wbv_cnt - v0, err_cnt - e0); end
    endtask

    task automatic test_reset_mid();
        int v0;
        wb_ready = 1'b1;
        send(1'b1, 1'b0, 32'd6, 32'h0, 5'd9);
        checks++; if (MemR !== 1'b1) begin errors++; $display("FAIL midrst_memr got %b want 1", MemR); end
        rst_n = 1'b0;
        step();
        checks++; if ({req_ready, MemR, MemW, wb_valid, err_range, busy} !== 6'b0) begin errors++; $display("FAIL midrst_flags got %b want 000000", {req_ready, MemR, MemW, wb_valid, err_range, busy}); end
        checks++; if ({address, wb_data, wb_rd} !== 69'h0) begin errors++; $display("FAIL midrst_data got %h want 0", {address, wb_data, wb_rd}); end
        rst_n = 1'b1;
        v0 = wbv_cnt;
        repeat (5) step();
        checks++; if (wbv_cnt - v0 !== 0) begin errors++; $display("FAIL midrst_no_resp got %0d want 0", wbv_cnt - v0); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", req_ready); end
    endtask

    task automatic test_forward();
        int k;
        send(1'b0, 1'b1, 32'd9, 32'hFFFF_FFFD, 5'd0);
        step();
        wb_ready = 1'b0;
        send(1'b1, 1'b0, 32'd9, 32'h0, 5'd2);
        checks++; if ({MemR, wb_valid} !== {!FWD, FWD}) begin errors++; $display("FAIL fwd_n1 got %b want %b", {MemR, wb_valid}, {!FWD, FWD}); end
        wait_wbv(k);
        checks++; if ({wb_rd, wb_data} !== {5'd2, 32'hFFFF_FFFD}) begin errors++; $display("FAIL fwd_data got %0d/%h want 2/fffffffd", wb_rd, wb_data); end
        wb_ready = 1'b1;
        step();
        checks++; if ({wb_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL fwd_done got %b want 01", {wb_valid, req_ready}); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_backpressure();
        test_range();
        test_special();
        test_reset_mid();
        test_forward();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL both_strobes got %0d want 0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
